ec_point_serializer: RTL and testbench

// - Encodes a 256-bit secp256k1 affine point (x,y) from scalar_multiplication into a SEC1 byte stream.
// - Supports uncompressed (0x04||X||Y, 65 B) and compressed (0x02/0x03||X, 33 B) frames.
// - Byte-serial valid/ready output feeds the host/UART link; this is the transmit end of the point interface.

---
 rtl/ec_point_serializer.sv | 140 ++++++++++++++
 tb/tb_ec_point_serializer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ec_point_serializer.sv
`default_nettype none
// ============================================================================
// Module      : ec_point_serializer
// Description : Emits an affine curve point (x,y) as a SEC1 byte stream,
//               uncompressed (04||X||Y) or compressed (02/03||X), over a
//               byte-serial valid/ready link. Optional macro
//               EC_SER_INFINITY_EN adds in_inf for the 1-byte 00 frame.
// Revision    : 1.0 - initial release
// ============================================================================
module ec_point_serializer #(
  parameter int COORD_W = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] x_in,
  input  logic [COORD_W-1:0] y_in,
  input  logic               compress,
`ifdef EC_SER_INFINITY_EN
  input  logic               in_inf,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic [15:0]        frames_sent
);

  localparam int NB = COORD_W / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IW-1:0] C_LAST_IDX = IW'(NB - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PREFIX = 2'd1,
    S_XB     = 2'd2,
    S_YB     = 2'd3
  } state_t;

  state_t             state_q;
  logic [COORD_W-1:0] sh_q;
  logic [COORD_W-1:0] y_q;
  logic               comp_q;
  logic [IW-1:0]      idx_q;
  logic [7:0]         data_q;
  logic               valid_q;
  logic               last_q;
  logic [15:0]        frames_q;

  logic               w_hs;
  logic               w_inf;
  logic [IW-1:0]      w_idx_nxt;

  assign w_hs      = valid_q && out_ready;
  assign w_idx_nxt = idx_q + IW'(1);
`ifdef EC_SER_INFINITY_EN
  assign w_inf     = in_inf;
`else
  assign w_inf     = 1'b0;
`endif

  // The byte on out_data is always the head of sh_q's previous contents;
  // sh_q shifts left one byte per handshake so the MSB byte goes first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sh_q     <= '0;
      y_q      <= '0;
      comp_q   <= 1'b0;
      idx_q    <= '0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      frames_q <= 16'h0000;
    end else if (state_q == S_IDLE) begin
      if (in_valid) begin
        sh_q    <= x_in;
        y_q     <= y_in;
        comp_q  <= compress;
        idx_q   <= '0;
        valid_q <= 1'b1;
        state_q <= S_PREFIX;
        if (w_inf) begin
          data_q <= 8'h00;
          last_q <= 1'b1;
        end else begin
          data_q <= compress ? {6'b000000, 1'b1, y_in[0]} : 8'h04;
          last_q <= 1'b0;
        end
      end
    end else if (w_hs) begin
      if (last_q) begin
        valid_q  <= 1'b0;
        last_q   <= 1'b0;
        state_q  <= S_IDLE;
        frames_q <= frames_q + 16'h0001;
      end else begin
        case (state_q)
          S_PREFIX: begin
            data_q  <= sh_q[COORD_W-1 -: 8];
            sh_q    <= sh_q << 8;
            idx_q   <= '0;
            last_q  <= comp_q && (NB == 1);
            state_q <= S_XB;
          end
          S_XB: begin
            if (idx_q == C_LAST_IDX) begin
              data_q  <= y_q[COORD_W-1 -: 8];
              sh_q    <= y_q << 8;
              idx_q   <= '0;
              last_q  <= (NB == 1);
              state_q <= S_YB;
            end else begin
              data_q <= sh_q[COORD_W-1 -: 8];
              sh_q   <= sh_q << 8;
              idx_q  <= w_idx_nxt;
              last_q <= comp_q && (w_idx_nxt == C_LAST_IDX);
            end
          end
          S_YB: begin
            data_q <= sh_q[COORD_W-1 -: 8];
            sh_q   <= sh_q << 8;
            idx_q  <= w_idx_nxt;
            last_q <= (w_idx_nxt == C_LAST_IDX);
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_data    = data_q;
  assign out_valid   = valid_q;
  assign out_last    = last_q;
  assign frames_sent = frames_q;

endmodule
`default_nettype wire

// File: tb/tb_ec_point_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ec_point_serializer
// Description : Self-checking bench for ec_point_serializer against a SEC1
//               frame model; honours EC_SER_INFINITY_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ec_point_serializer;

  localparam int COORD_W = 256;
  localparam int NB      = COORD_W / 8;
  localparam logic [255:0] C_GX =
    256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
  localparam logic [255:0] C_GY =
    256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [COORD_W-1:0] x_in = '0;
  logic [COORD_W-1:0] y_in = '0;
  logic               compress = 1'b0;
  logic               in_inf = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [7:0]         out_data;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic               out_last;
  logic [15:0]        frames_sent;

  ec_point_serializer #(.COORD_W(COORD_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .x_in        (x_in),
    .y_in        (y_in),
    .compress    (compress),
`ifdef EC_SER_INFINITY_EN
    .in_inf      (in_inf),
`endif
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .frames_sent (frames_sent)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       l;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_cyc = 0;
  int          acc_cnt = 0;
  int          fbytes = 0;
  int          rdy_mode = 0;
  int          bp_cnt = 0;
  logic        busy = 1'b0;
  logic        b2b_chk = 1'b0;
  logic [15:0] mdl_frames = 16'h0000;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h00;
  logic        prev_last = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // SEC1 framing: prefix, then X big-endian, then Y big-endian unless compressed.
  task automatic push_frame(input logic [255:0] x, input logic [255:0] y,
                            input logic c, input logic inf);
    exp_t e;
    e.l = 1'b0;
    if (inf) begin
      e.b = 8'h00;
      exp_q.push_back(e);
    end else begin
      e.b = c ? (y[0] ? 8'h03 : 8'h02) : 8'h04;
      exp_q.push_back(e);
      for (int i = NB - 1; i >= 0; i--) begin
        e.b = 8'((x >> (8 * i)) & 256'hFF);
        exp_q.push_back(e);
      end
      if (!c) begin
        for (int i = NB - 1; i >= 0; i--) begin
          e.b = 8'((y >> (8 * i)) & 256'hFF);
          exp_q.push_back(e);
        end
      end
    end
    exp_q[exp_q.size() - 1].l = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (reset) begin
      exp_q.delete();
      busy       = 1'b0;
      mdl_frames = 16'h0000;
      prev_stall = 1'b0;
      fbytes     = 0;
    end else begin
      chk("in_ready", 64'(in_ready), 64'(!busy));
      chk("out_valid", 64'(out_valid), 64'(busy));
      chk("frames_sent", 64'(frames_sent), 64'(mdl_frames));
      if (prev_stall && out_valid) begin
        chk("stall_data", 64'(out_data), 64'(prev_data));
        chk("stall_last", 64'(out_last), 64'(prev_last));
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("byte_expected", 64'(exp_q.size()), 64'(1));
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 64'(out_data), 64'(e.b));
          chk("out_last", 64'(out_last), 64'(e.l));
          fbytes++;
          if (e.l) begin
            busy       = 1'b0;
            mdl_frames = mdl_frames + 16'h0001;
            last_cyc   = cyc;
            fbytes     = 0;
          end
        end
      end
      if (in_valid && in_ready) begin
`ifdef EC_SER_INFINITY_EN
        push_frame(x_in, y_in, compress, in_inf);
`else
        push_frame(x_in, y_in, compress, 1'b0);
`endif
        busy = 1'b1;
        acc_cnt++;
        if (b2b_chk) chk("b2b_gap", 64'(cyc - last_cyc), 64'(1));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1: out_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (fbytes < 10) begin
          out_ready = 1'b1;
          bp_cnt    = 0;
        end else if (bp_cnt < 5) begin
          out_ready = 1'b0;
          bp_cnt++;
        end else begin
          out_ready = (bp_cnt % 2) == 1;
          bp_cnt++;
        end
      end
      default: out_ready = 1'b1;
    endcase
  end

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
    return r;
  endfunction

  task automatic wait_idle(input int bound);
    int   n;
    logic done;
    n    = 0;
    done = 1'b0;
    while (!done && n < bound) begin
      @(posedge clk);
      #1;
      n++;
      done = !busy && in_ready;
    end
    chk("idle_timeout", 64'(done), 64'(1));
  endtask

  task automatic send(input logic [255:0] x, input logic [255:0] y,
                      input logic c, input logic inf);
    int n;
    n = 0;
    while (!in_ready && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    x_in = x; y_in = y; compress = c; in_inf = inf; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x_in = rnd256(); y_in = rnd256(); compress = ~c;
    wait_idle(2000);
  endtask

  task automatic wait_acc(input int target);
    int n;
    n = 0;
    while (acc_cnt < target && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("accept_timeout", 64'(acc_cnt >= target), 64'(1));
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_last", 64'(out_last), 64'(0));
    chk("rst_frames", 64'(frames_sent), 64'(0));
    @(posedge clk);
    #1;

    send(C_GX, C_GY, 1'b0, 1'b0);
    chk("g_unc_frames", 64'(frames_sent), 64'(1));
    chk("g_unc_in_ready", 64'(in_ready), 64'(1));
    send(C_GX, C_GY, 1'b1, 1'b0);
    send(C_GX, C_GY + 256'd1, 1'b1, 1'b0);
    chk("g_cmp_frames", 64'(frames_sent), 64'(3));

    rdy_mode = 2;
    send(C_GX, C_GY, 1'b0, 1'b0);
    rdy_mode = 0;
    @(posedge clk);
    #1;

    x_in = C_GX; y_in = C_GY; compress = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (fbytes < 20 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    chk("midrst_frames", 64'(frames_sent), 64'(0));
    @(posedge clk);
    #1;
    send(C_GX, C_GY, 1'b0, 1'b0);

    n = acc_cnt;
    x_in = rnd256(); y_in = rnd256(); compress = 1'b0; in_valid = 1'b1;
    wait_acc(n + 1);
    b2b_chk = 1'b1;
    x_in = rnd256(); y_in = rnd256(); compress = 1'b1;
    wait_acc(n + 2);
    in_valid = 1'b0;
    b2b_chk  = 1'b0;
    wait_idle(2000);
    chk("b2b_frames", 64'(frames_sent), 64'(3));

    force dut.frames_q = 16'hFFFF;
    mdl_frames = 16'hFFFF;
    @(posedge clk);
    #1 release dut.frames_q;
    send(rnd256(), rnd256(), 1'b1, 1'b0);
    chk("wrap_frames", 64'(frames_sent), 64'(16'h0000));

    // With the optional port absent, in_inf is not connected and a normal frame results.
    send(C_GX, C_GY, 1'b0, 1'b1);

    rdy_mode = 1;
    for (int i = 0; i < 12; i++) send(rnd256(), rnd256(), 1'($urandom_range(0, 1)), 1'b0);
    rdy_mode = 0;
    chk("final_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
